// File: rtl/vdata_seg_scanner_if.sv
// Connects the display-value selector to the 7-segment scanner.
// The selector is the master. The scanner is the slave and drives the board display pins.
interface vdata_seg_scanner_if;
    logic [31:0] Vdata;
    logic        HOLD;
    logic        BLANK_LZ;
    logic [6:0]  SEG;
    logic        DP;
    logic [7:0]  AN;
    logic        FRAME;

    modport master (
        output Vdata, HOLD, BLANK_LZ,
        input  SEG, DP, AN, FRAME
    );

    modport slave (
        input  Vdata, HOLD, BLANK_LZ,
        output SEG, DP, AN, FRAME
    );
endinterface

// File: rtl/vdata_seg_scanner.sv
// Shows a 32-bit value in hex on an 8-digit multiplexed common-anode display.
// The value is captured only at a frame wrap, so the display never tears.
module vdata_seg_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2,
    parameter int HALF_DP  = 1
) (
    input  logic               CLK,
    input  logic               RST,
    vdata_seg_scanner_if.slave bus
);
    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic          DP_EN    = (HALF_DP != 0);

    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [31:0]   disp_reg;
    logic [7:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_reg;

    logic [3:0]    nib_arr [8];
    logic [7:0]    zero_above;
    logic          guard_ok;
    logic          slot_end;
    logic          frame_wrap;
    logic          blank;
    logic          lit;
    logic [6:0]    hex_seg;

    // zero_above[i] is set when digit i and every digit to its left are zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign nib_arr[gi]    = disp_reg[4*gi +: 4];
            assign zero_above[gi] = ~|disp_reg[31:4*gi];
        end
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (cnt_reg >= CW'(GUARD));
        end
    endgenerate

    assign slot_end   = (cnt_reg == CNT_LAST);
    assign frame_wrap = slot_end && (idx_reg == 3'd7);
    assign blank      = bus.BLANK_LZ && (idx_reg != 3'd0) && zero_above[idx_reg];
    assign lit        = guard_ok && !blank;

    always_comb begin
        hex_seg = 7'h7F;
        case (nib_arr[idx_reg])
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            disp_reg  <= 32'h0;
            an_reg    <= 8'hFF;
            seg_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            frame_reg <= frame_wrap;
            if (frame_wrap && !bus.HOLD) begin
                disp_reg <= bus.Vdata;
            end
            // Outputs use the pre-edge scan position, so they trail cnt/idx by one cycle.
            an_reg  <= lit ? ~(8'h01 << idx_reg) : 8'hFF;
            seg_reg <= lit ? hex_seg : 7'h7F;
            dp_reg  <= !(DP_EN && (idx_reg == 3'd4) && lit);
        end
    end

    assign bus.AN    = an_reg;
    assign bus.SEG   = seg_reg;
    assign bus.DP    = dp_reg;
    assign bus.FRAME = frame_reg;
endmodule

// File: tb/tb_vdata_seg_scanner.sv
// Self-checking bench for vdata_seg_scanner: table vectors, hand sequences and random stimulus.
// Three instances (guard on/off, decimal point on/off) are checked against a frame-level model.
module tb_vdata_seg_scanner;
    localparam int SD        = 4;
    localparam int FRAME_LEN = 8 * SD;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] vdata;
    logic        hold;
    logic        blz;

    always #5 clk = ~clk;

    vdata_seg_scanner_if bus_a ();
    vdata_seg_scanner_if bus_b ();
    vdata_seg_scanner_if bus_c ();

    assign bus_a.Vdata = vdata;  assign bus_a.HOLD = hold;  assign bus_a.BLANK_LZ = blz;
    assign bus_b.Vdata = vdata;  assign bus_b.HOLD = hold;  assign bus_b.BLANK_LZ = blz;
    assign bus_c.Vdata = vdata;  assign bus_c.HOLD = hold;  assign bus_c.BLANK_LZ = blz;

    vdata_seg_scanner #(.SCAN_DIV(SD), .GUARD(1), .HALF_DP(0)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    vdata_seg_scanner #(.SCAN_DIV(SD), .GUARD(0), .HALF_DP(0)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
    vdata_seg_scanner #(.SCAN_DIV(SD), .GUARD(1), .HALF_DP(1)) dut_c (.CLK(clk), .RST(rst), .bus(bus_c));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_n      = 0;      // edges since reset release
    logic [31:0] m_disp   = 32'h0;  // value the display holds in the model

    typedef struct {
        logic [31:0] vdata;
        logic        blz;
        logic [55:0] segs;  // {digit7 .. digit0}, 7'h7F = dark
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {AN, SEG, DP} after an edge whose pre-edge position is n cycles into the scan.
    function automatic logic [15:0] model_out(input int guard, input bit half_dp, input int n,
                                              input logic [31:0] disp, input logic blank_lz);
        int          cnt;
        int          idx;
        logic [31:0] upper;
        logic        on;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        cnt   = n % SD;
        idx   = (n / SD) % 8;
        upper = disp >> (4 * idx);
        on    = (cnt >= guard) && !(blank_lz && idx != 0 && upper == 32'h0);
        an    = on ? ~(8'h01 << idx) : 8'hFF;
        seg   = on ? HEX[upper[3:0]] : 7'h7F;
        dp    = !(half_dp && idx == 4 && on);
        return {an, seg, dp};
    endfunction

    task automatic tick();
        logic [16:0] ea, eb, ec;
        logic        ef;
        @(posedge clk);
        if (!rst) begin
            ea = {8'hFF, 7'h7F, 1'b1, 1'b0};
            eb = ea;
            ec = ea;
        end else begin
            ef = ((m_n % FRAME_LEN) == FRAME_LEN - 1);
            ea = {model_out(1, 1'b0, m_n, m_disp, blz), ef};
            eb = {model_out(0, 1'b0, m_n, m_disp, blz), ef};
            ec = {model_out(1, 1'b1, m_n, m_disp, blz), ef};
        end
        if (!rst) begin
            m_n    = 0;
            m_disp = 32'h0;
        end else begin
            if (((m_n % FRAME_LEN) == FRAME_LEN - 1) && !hold) m_disp = vdata;
            m_n++;
        end
        #1;
        check("dut_a {AN,SEG,DP,FRAME}", 32'({bus_a.AN, bus_a.SEG, bus_a.DP, bus_a.FRAME}), 32'(ea));
        check("dut_b {AN,SEG,DP,FRAME}", 32'({bus_b.AN, bus_b.SEG, bus_b.DP, bus_b.FRAME}), 32'(eb));
        check("dut_c {AN,SEG,DP,FRAME}", 32'({bus_c.AN, bus_c.SEG, bus_c.DP, bus_c.FRAME}), 32'(ec));
    endtask

    task automatic wait_frame(output int ticks);
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (bus_a.FRAME !== 1'b1 && ticks < 200);
        if (bus_a.FRAME !== 1'b1) check("FRAME pulse timeout", 32'(bus_a.FRAME), 32'd1);
    endtask

    // Runs one full frame right after a FRAME pulse and checks every digit of dut_a.
    task automatic collect(input string tag, input logic [55:0] exp_segs);
        logic [6:0] seen [8];
        int         dp_low_a;
        int         dp_low_c;
        dp_low_a = 0;
        dp_low_c = 0;
        for (int d = 0; d < 8; d++) seen[d] = 7'h7F;
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick();
            for (int d = 0; d < 8; d++) if (bus_a.AN == ~(8'h01 << d)) seen[d] = bus_a.SEG;
            if (bus_a.DP == 1'b0) dp_low_a++;
            if (bus_c.DP == 1'b0) dp_low_c++;
        end
        for (int d = 0; d < 8; d++)
            check($sformatf("%s digit%0d SEG", tag, d), 32'(seen[d]), 32'(exp_segs[7*d +: 7]));
        check($sformatf("%s DP low cycles (HALF_DP=0)", tag), dp_low_a, 0);
        check($sformatf("%s DP low cycles (HALF_DP=1)", tag), dp_low_c,
              (exp_segs[28 +: 7] == 7'h7F) ? 0 : SD - 1);
        $display("frame %-16s vdata=%h blz=%b hold=%b segs=%h", tag, vdata, blz, hold, exp_segs);
    endtask

    initial begin
        int          t;
        int          frames;
        logic [6:0]  seen [8];

        vecs[0] = '{32'h12345678, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[1] = '{32'h000000A0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[2] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{32'h00F00001, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};
        vecs[4] = '{32'h89ABCDEF, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[5] = '{32'h0000BEEF, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[6] = '{32'h0000BEEF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[7] = '{32'h00000000, 1'b0, {8{7'h40}}};
        vecs[8] = '{32'h10000000, 1'b1, {7'h79, {7{7'h40}}}};

        // Reset held for three cycles, then the first frame shows zeros.
        rst = 1'b0; vdata = 32'h12345678; hold = 1'b0; blz = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        wait_frame(t);
        check("first FRAME after release (cycles)", t, FRAME_LEN);
        collect("after-reset", vecs[0].segs);

        // FRAME appears exactly once every frame period.
        frames = 0;
        for (int k = 0; k < 3 * FRAME_LEN; k++) begin
            tick();
            if (bus_a.FRAME === 1'b1) frames++;
        end
        check("FRAME pulses in 3 frames", frames, 3);

        for (int i = 0; i < 9; i++) begin
            vdata = vecs[i].vdata; blz = vecs[i].blz; hold = 1'b0;
            wait_frame(t);
            collect($sformatf("vec%0d", i), vecs[i].segs);
        end

        // HOLD freezes the display while FRAME keeps pulsing.
        vdata = 32'h11111111; blz = 1'b0;
        wait_frame(t);
        collect("hold-pre", {8{7'h79}});
        hold = 1'b1; vdata = 32'h22222222;
        frames = 0;
        for (int k = 0; k < 3 * FRAME_LEN; k++) begin
            tick();
            if (bus_a.FRAME === 1'b1) frames++;
        end
        check("FRAME pulses while HOLD", frames, 3);
        collect("hold-frozen", {8{7'h79}});
        hold = 1'b0;
        wait_frame(t);
        collect("hold-released", {8{7'h24}});

        // Changing Vdata mid-frame must not tear the current frame.
        vdata = 32'hAAAAAAAA;
        wait_frame(t);
        collect("tear-pre", {8{7'h08}});
        t = 0;
        do begin tick(); t++; end while (bus_a.AN !== 8'hF7 && t < 100);
        check("reach digit3", 32'(bus_a.AN), 32'hF7);
        vdata = 32'h55555555;
        for (int d = 0; d < 8; d++) seen[d] = 7'h7F;
        t = 0;
        do begin
            tick(); t++;
            for (int d = 4; d < 8; d++) if (bus_a.AN == ~(8'h01 << d)) seen[d] = bus_a.SEG;
        end while (bus_a.FRAME !== 1'b1 && t < 100);
        for (int d = 4; d < 8; d++) check($sformatf("no-tear digit%0d SEG", d), 32'(seen[d]), 32'h08);
        collect("tear-post", {8{7'h12}});

        // Reset asserted mid-scan at idx=5, cnt=2.
        t = 0;
        while ((m_n % FRAME_LEN) != 5 * SD + 2 && t < 100) begin tick(); t++; end
        rst = 1'b0;
        tick();
        check("mid-scan reset {AN,SEG,FRAME}", 32'({bus_a.AN, bus_a.SEG, bus_a.FRAME}), 32'({8'hFF, 7'h7F, 1'b0}));
        rst = 1'b1;
        wait_frame(t);
        check("FRAME after mid-scan reset (cycles)", t, FRAME_LEN);
        collect("post-midscan", {8{7'h12}});

        // Random stimulus against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) vdata = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            if ($urandom_range(0, 29) == 0) blz = ~blz;
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
